// File: rtl/transposable_state_mem.sv
// SLICES x LANES bit store with registered row and column views, range/busy
// checking and a ready/valid streaming dump of all rows.
module transposable_state_mem #(
    parameter int SLICES = 64,
    parameter int LANES  = 25,
    parameter int SA     = $clog2(SLICES),
    parameter int LA     = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SA-1:0]     slc_adr,
    input  logic [LANES-1:0]  slc_wdata,
    input  logic              slc_we,
    input  logic              slc_re,
    output logic [LANES-1:0]  slc_rdata,
    input  logic [LA-1:0]     lane_adr,
    input  logic [SLICES-1:0] lane_wdata,
    input  logic              lane_we,
    input  logic              lane_re,
    output logic [SLICES-1:0] lane_rdata,
    output logic              rd_valid,
    output logic              err,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_last,
    output logic [LANES-1:0]  dump_data,
    output logic              busy
);
    typedef enum logic {IDLE, DUMP} state_t;

    state_t            state_q;
    logic [LANES-1:0]  mem_q [SLICES];
    logic [SA-1:0]     ptr_q, ptr_d;
    logic [LANES-1:0]  slc_rdata_q, dump_data_q;
    logic [SLICES-1:0] lane_rdata_q, lane_col;
    logic              rd_valid_q, err_q, busy_q, dump_valid_q, dump_last_q;
    logic              slc_ok, lane_ok, slc_rd, lane_rd, slc_wr, lane_wr, bad_req;

    assign slc_ok  = int'(slc_adr) < SLICES;
    assign lane_ok = int'(lane_adr) < LANES;
    assign slc_rd  = mode & slc_re;
    assign lane_rd = ~mode & lane_re;
    assign slc_wr  = mode & slc_we & slc_ok & ~busy_q;
    assign lane_wr = ~mode & lane_we & lane_ok & ~busy_q;
    // Writes are refused for the whole dump so the stream is a consistent snapshot.
    assign bad_req = mode ? (((slc_re | slc_we) & ~slc_ok) | (slc_we & busy_q))
                          : (((lane_re | lane_we) & ~lane_ok) | (lane_we & busy_q));
    assign ptr_d   = ptr_q + 1'b1;

    always_comb begin
        lane_col = '0;
        for (int r = 0; r < SLICES; r++) lane_col[r] = mem_q[r][lane_adr];
    end

    // Reads sample mem_q before this edge's write lands, giving pre-write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < SLICES; r++) mem_q[r] <= '0;
            slc_rdata_q  <= '0;
            lane_rdata_q <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (slc_wr) mem_q[slc_adr] <= slc_wdata;
            if (lane_wr) begin
                for (int r = 0; r < SLICES; r++) mem_q[r][lane_adr] <= lane_wdata[r];
            end
            if (slc_rd)  slc_rdata_q  <= slc_ok ? mem_q[slc_adr] : '0;
            if (lane_rd) lane_rdata_q <= lane_ok ? lane_col : '0;
            rd_valid_q <= slc_rd | lane_rd;
            err_q      <= bad_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            busy_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (dump_start) begin
                    state_q      <= DUMP;
                    ptr_q        <= '0;
                    busy_q       <= 1'b1;
                    dump_valid_q <= 1'b1;
                    dump_last_q  <= (SLICES == 1);
                    dump_data_q  <= mem_q[0];
                end
                DUMP: if (dump_ready) begin
                    if (dump_last_q) begin
                        state_q      <= IDLE;
                        ptr_q        <= '0;
                        busy_q       <= 1'b0;
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                        dump_data_q  <= '0;
                    end else begin
                        ptr_q       <= ptr_d;
                        dump_data_q <= mem_q[ptr_d];
                        dump_last_q <= (ptr_d == SA'(SLICES - 1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign slc_rdata  = slc_rdata_q;
    assign lane_rdata = lane_rdata_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_last  = dump_last_q;
    assign dump_data  = dump_data_q;
endmodule

// File: tb/tb_transposable_state_mem.sv
// Directed bench for transposable_state_mem: row/column access, range errors,
// same-cycle read/write, stalled dump streaming and reset during a dump.
module tb_transposable_state_mem;
    logic        clk = 1'b0;
    logic        rst, mode;
    logic [5:0]  slc_adr;
    logic [24:0] slc_wdata, slc_rdata, dump_data;
    logic        slc_we, slc_re;
    logic [4:0]  lane_adr;
    logic [63:0] lane_wdata, lane_rdata;
    logic        lane_we, lane_re, rd_valid, err;
    logic        dump_start, dump_ready, dump_valid, dump_last, busy;
    int          n_vec = 0;
    int          n_bad = 0;

    transposable_state_mem dut (
        .clk(clk), .rst(rst), .mode(mode),
        .slc_adr(slc_adr), .slc_wdata(slc_wdata), .slc_we(slc_we), .slc_re(slc_re),
        .slc_rdata(slc_rdata),
        .lane_adr(lane_adr), .lane_wdata(lane_wdata), .lane_we(lane_we), .lane_re(lane_re),
        .lane_rdata(lane_rdata),
        .rd_valid(rd_valid), .err(err),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
        .dump_last(dump_last), .dump_data(dump_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] pat(int r);
        return 25'h1000000 | 25'(r << 8) | 25'(r);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        slc_we = 1'b0; slc_re = 1'b0; lane_we = 1'b0; lane_re = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic wr_row(input logic [5:0] a, input logic [24:0] d);
        mode = 1'b1; slc_adr = a; slc_wdata = d; slc_we = 1'b1;
        tick;
        slc_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 1'b1; slc_adr = '0; slc_wdata = '0; lane_adr = '0;
        lane_wdata = '0; dump_ready = 1'b0;
        idle_inputs;
        tick; tick;
        n_vec++; if (slc_rdata !== 25'h0) begin n_bad++; $display("FAIL reset_slc_rdata got %h want 0", slc_rdata); end
        n_vec++; if (lane_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_lane_rdata got %h want 0", lane_rdata); end
        n_vec++; if ({rd_valid, err, dump_valid, dump_last, busy} !== 5'b0)
            begin n_bad++; $display("FAIL reset_flags got %b want 00000", {rd_valid, err, dump_valid, dump_last, busy}); end
        n_vec++; if (dump_data !== 25'h0) begin n_bad++; $display("FAIL reset_dump_data got %h want 0", dump_data); end
        @(negedge clk); rst = 1'b0;
        tick;
    endtask

    task automatic test_row_rw;
        wr_row(6'd5, 25'h1ABCDEF);
        slc_re = 1'b1; slc_adr = 6'd5;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== 25'h1ABCDEF) begin n_bad++; $display("FAIL row_read got %h want 1abcdef", slc_rdata); end
        n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL row_rd_valid got %b want 1", rd_valid); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL row_err got %b want 0", err); end
        tick;
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_pulse got %b want 0", rd_valid); end
    endtask

    task automatic test_transpose;
        for (int r = 0; r < 64; r++) wr_row(6'(r), 25'd1 << (r % 25));
        mode = 1'b0; lane_adr = 5'd3; lane_re = 1'b1;
        tick;
        lane_re = 1'b0;
        n_vec++; if (lane_rdata !== 64'h0020_0000_1000_0008) begin n_bad++; $display("FAIL transpose_lane3 got %h want 0020000010000008", lane_rdata); end
        n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL transpose_rd_valid got %b want 1", rd_valid); end
        n_vec++; if (slc_rdata !== 25'h1ABCDEF) begin n_bad++; $display("FAIL row_view_hold got %h want 1abcdef", slc_rdata); end
    endtask

    task automatic test_lane_write;
        mode = 1'b0; lane_adr = 5'd0; lane_wdata = 64'hFFFF_0000_FFFF_0000; lane_we = 1'b1;
        tick;
        lane_we = 1'b0; lane_re = 1'b1;
        tick;
        lane_re = 1'b0;
        n_vec++; if (lane_rdata !== 64'hFFFF_0000_FFFF_0000) begin n_bad++; $display("FAIL lane0_readback got %h want ffff0000ffff0000", lane_rdata); end
        mode = 1'b1; slc_adr = 6'd16; slc_re = 1'b1;
        tick;
        n_vec++; if (slc_rdata !== 25'h0010001) begin n_bad++; $display("FAIL row16_after_lane got %h want 0010001", slc_rdata); end
        slc_adr = 6'd0;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== 25'h0000000) begin n_bad++; $display("FAIL row0_after_lane got %h want 0000000", slc_rdata); end
    endtask

    task automatic test_same_cycle;
        mode = 1'b1; slc_adr = 6'd63; slc_wdata = 25'h1555555; slc_we = 1'b1; slc_re = 1'b1;
        tick;
        slc_we = 1'b0;
        n_vec++; if (slc_rdata !== 25'h0002001) begin n_bad++; $display("FAIL same_adr_old_data got %h want 0002001", slc_rdata); end
        tick;
        n_vec++; if (slc_rdata !== 25'h1555555) begin n_bad++; $display("FAIL same_adr_new_data got %h want 1555555", slc_rdata); end
        slc_re = 1'b0;
        wr_row(6'd61, 25'h0AAAAAA);
        slc_adr = 6'd62; slc_re = 1'b1;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== 25'h0001001) begin n_bad++; $display("FAIL row62_read got %h want 0001001", slc_rdata); end
        slc_adr = 6'd61; slc_re = 1'b1;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== 25'h0AAAAAA) begin n_bad++; $display("FAIL row61_written got %h want 0aaaaaa", slc_rdata); end
    endtask

    task automatic test_range;
        mode = 1'b0; lane_adr = 5'd30; lane_re = 1'b1;
        tick;
        lane_re = 1'b0;
        n_vec++; if (lane_rdata !== 64'h0) begin n_bad++; $display("FAIL oor_lane_data got %h want 0", lane_rdata); end
        n_vec++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL oor_rd_valid got %b want 1", rd_valid); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err got %b want 1", err); end
        tick;
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b want 0", err); end
        lane_adr = 5'd27; lane_we = 1'b1; lane_wdata = '1;
        tick;
        lane_we = 1'b0;
        n_vec++; if ({err, rd_valid} !== 2'b10) begin n_bad++; $display("FAIL oor_lane_write got %b want 10", {err, rd_valid}); end
        mode = 1'b1; lane_adr = 5'd30; lane_re = 1'b1;
        tick;
        lane_re = 1'b0;
        n_vec++; if ({err, rd_valid} !== 2'b00) begin n_bad++; $display("FAIL unselected_view got %b want 00", {err, rd_valid}); end
    endtask

    task automatic test_dump;
        int beat, cyc;
        logic [24:0] held;
        logic stalled;
        for (int r = 0; r < 64; r++) wr_row(6'(r), pat(r));
        mode = 1'b1; dump_ready = 1'b0; dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dump_busy_rise got %b want 1", busy); end
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat < 64 && cyc < 400) begin
            dump_ready = cyc[0];
            slc_we = (cyc == 10); slc_adr = 6'd2; slc_wdata = 25'h0;
            dump_start = (cyc == 20);
            if (stalled) begin
                n_vec++; if (dump_data !== held) begin n_bad++; $display("FAIL dump_stall_hold got %h want %h", dump_data, held); end
            end
            n_vec++; if (dump_valid !== 1'b1) begin n_bad++; $display("FAIL dump_valid beat %0d got %b want 1", beat, dump_valid); end
            n_vec++; if (dump_data !== pat(beat)) begin n_bad++; $display("FAIL dump_data beat %0d got %h want %h", beat, dump_data, pat(beat)); end
            n_vec++; if (dump_last !== (beat == 63)) begin n_bad++; $display("FAIL dump_last beat %0d got %b want %b", beat, dump_last, beat == 63); end
            held = dump_data;
            stalled = ~dump_ready;
            if (dump_ready) beat++;
            tick;
            if (cyc == 10) begin
                n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL write_in_dump_err got %b want 1", err); end
            end
            cyc++;
        end
        idle_inputs; dump_ready = 1'b0;
        n_vec++; if (beat != 64) begin n_bad++; $display("FAIL dump_beats got %0d want 64", beat); end
        n_vec++; if ({busy, dump_valid} !== 2'b00) begin n_bad++; $display("FAIL dump_end got %b want 00", {busy, dump_valid}); end
        slc_adr = 6'd2; slc_re = 1'b1;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== pat(2)) begin n_bad++; $display("FAIL dump_write_dropped got %h want %h", slc_rdata, pat(2)); end
    endtask

    task automatic test_reset_mid_dump;
        int beat, cyc;
        logic [24:0] exp_d;
        dump_ready = 1'b1; dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        n_vec++; if (dump_data !== pat(10)) begin n_bad++; $display("FAIL beat10_data got %h want %h", dump_data, pat(10)); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({busy, dump_valid, dump_last} !== 3'b000) begin n_bad++; $display("FAIL async_abort got %b want 000", {busy, dump_valid, dump_last}); end
        n_vec++; if (dump_data !== 25'h0) begin n_bad++; $display("FAIL async_abort_data got %h want 0", dump_data); end
        @(negedge clk); rst = 1'b0;
        tick; tick;
        n_vec++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL no_beats_after_rst got %b want 0", dump_valid); end
        mode = 1'b1; slc_adr = 6'd10; slc_re = 1'b1;
        tick;
        slc_re = 1'b0;
        n_vec++; if (slc_rdata !== 25'h0) begin n_bad++; $display("FAIL mem_cleared got %h want 0", slc_rdata); end
        wr_row(6'd0, 25'h0123456);
        wr_row(6'd63, 25'h1FFFFFF);
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        beat = 0; cyc = 0;
        while (dump_valid === 1'b1 && cyc < 200) begin
            exp_d = (beat == 0) ? 25'h0123456 : (beat == 63) ? 25'h1FFFFFF : 25'h0;
            n_vec++; if (dump_data !== exp_d) begin n_bad++; $display("FAIL redump_data beat %0d got %h want %h", beat, dump_data, exp_d); end
            n_vec++; if (dump_last !== (beat == 63)) begin n_bad++; $display("FAIL redump_last beat %0d got %b want %b", beat, dump_last, beat == 63); end
            beat++; cyc++;
            tick;
        end
        n_vec++; if (beat != 64) begin n_bad++; $display("FAIL redump_beats got %0d want 64", beat); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL redump_busy_fall got %b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_row_rw;
        test_transpose;
        test_lane_write;
        test_same_cycle;
        test_range;
        test_dump;
        test_reset_mid_dump;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
